// File: rtl/filter_pkg.sv
// Shared types and constants for the sliding-window filter controller.
// The coordinate width helper keeps degenerate one-pixel dimensions at a legal width.
package filter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;
    localparam int DEF_K     = 3;

    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order column/row counter that advances once per accepted pixel.
// Wraps column into row, and row back to zero after the last line.
module raster_counter
    import filter_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      inc,
    output logic [coord_w(IMG_W)-1:0] col,
    output logic [coord_w(IMG_H)-1:0] row,
    output logic                      last
);

    localparam int CW = coord_w(IMG_W);
    localparam int RW = coord_w(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col <= '0;
            row <= '0;
        end else if (inc) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign last = (col == COL_MAX) && (row == ROW_MAX);

endmodule

// File: rtl/filter_window_ctrl.sv
// Sequencer for the KxK sliding window: gates the shared shift enable, tracks raster
// position and flags when the window registers hold a complete in-image window.
module filter_window_ctrl
    import filter_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int K     = DEF_K
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      out_ready,
    output logic                      shift_en,
    output logic                      win_valid,
    output logic [coord_w(IMG_W)-1:0] win_col,
    output logic [coord_w(IMG_H)-1:0] win_row,
    output logic                      busy,
    output logic                      done
);

    localparam int CW = coord_w(IMG_W);
    localparam int RW = coord_w(IMG_H);
    localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);
    localparam logic [CW-1:0] HALF_COL = CW'((K - 1) / 2);
    localparam logic [RW-1:0] HALF_ROW = RW'((K - 1) / 2);

    state_t state, next_state;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last;
    logic          clr;
    logic          completes;

    raster_counter #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) u_raster_counter (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (shift_en),
        .col (col),
        .row (row),
        .last(last)
    );

    assign shift_en  = in_valid & in_ready;
    assign completes = (row >= ROW_MIN) && (col >= COL_MIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A held, unconsumed window blocks new pixels so the window registers do not move under it.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        clr        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                    clr        = 1'b1;
                end
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = ~win_valid | out_ready;
                if (in_valid && in_ready && last) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!win_valid || out_ready) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Row-start pixels never raise win_valid, which hides the stale wrap-around window.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_col   <= '0;
            win_row   <= '0;
        end else if (shift_en && completes) begin
            win_valid <= 1'b1;
            win_col   <= col - HALF_COL;
            win_row   <= row - HALF_ROW;
        end else if (win_valid && out_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule

// File: doc/filter_window_ctrl.md
Name: filter_window_ctrl

Overview:
- Sequencer for the K×K sliding-window datapath of the image filter. The window is built from 8-bit enabled registers and line buffers.
- Accepts a raster-order pixel stream through a valid/ready handshake.
- Produces the single shared enable that shifts every window register and line-buffer stage.
- Tracks column and row, and flags when the window is fully inside the image so the downstream filter kernel can consume it.

Parameters:
- IMG_W, 640, image width in pixels (≥ K).
- IMG_H, 480, image height in lines (≥ K).
- K, 3, window size. Odd, 3 or 5.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame. Honoured only in IDLE.
- in_valid  in  1  upstream pixel present.
- in_ready  out  1  controller can accept a pixel this cycle.
- out_ready  in  1  downstream kernel consumes the current window.
- shift_en  out  1  enable for all window registers and line buffers. Equals in_valid & in_ready.
- win_valid  out  1  window registers hold a complete in-image window.
- win_col  out  $clog2(IMG_W)  column of the window centre pixel.
- win_row  out  $clog2(IMG_H)  row of the window centre pixel.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: state IDLE; col, row, win_col, win_row = 0; win_valid, busy, done = 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready = 0.
  - start → RUN, with col = 0 and row = 0.
- RUN:
  - in_ready = ~win_valid | out_ready. This stalls the window while an unconsumed window is held.
  - shift_en is combinational: in_valid & in_ready. Window registers latch on the same edge the pixel is accepted.
- Accept, i.e. shift_en = 1:
  - col increments by one.
  - At col = IMG_W−1, col wraps to 0 and row increments.
  - Counters never exceed IMG_W−1 / IMG_H−1.
- Window validity: on the edge following an accept at (row, col) with row ≥ K−1 and col ≥ K−1:
  - win_valid <= 1.
  - win_col <= col − (K−1)/2.
  - win_row <= row − (K−1)/2.
  - Latency from pixel accept to win_valid is 1 cycle.
- Accept whose pixel does not complete a window: win_valid <= 0 if out_ready, otherwise it holds. This cannot happen while win_valid=1 & ~out_ready, because in_ready = 0 then.
- Consume without a new accept: win_valid & out_ready → win_valid <= 0.
- Simultaneous consume and new valid accept: win_valid stays 1 and the coordinates update, giving back-to-back windows at full rate.
- Row-start columns (col < K−1): pixels shift in but produce no window. The stale wrap-around window is suppressed.
- Last pixel, (IMG_H−1, IMG_W−1):
  - RUN → DRAIN.
  - col and row reset to 0.
  - in_ready = 0 in DRAIN.
- DRAIN: leaves to DONE once win_valid is 0, or on the cycle out_ready consumes it.
- DONE: done = 1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- rst mid-frame: returns to IDLE next edge. win_valid drops, and window contents are irrelevant (not cleared).
- in_valid outside RUN is ignored. shift_en = 0.

Decomposition:
- Package filter_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - Default IMG_W, IMG_H, K constants.
  - Width helpers for coordinate widths.
- One natural sub-module: raster_counter. It is parameterised by IMG_W/IMG_H, with inputs clk, rst, clr, inc and outputs col, row, last. Used by the controller.

Test Plan (IMG_W=4, IMG_H=3, K=3 unless stated):
- Full-rate frame: start, in_valid and out_ready held 1 → 12 shift_en pulses. Exactly 2 windows: (win_row,win_col) = (1,1) one cycle after pixel 10 is accepted, and (1,2) one cycle after pixel 11. Then done pulses once, and busy is 0 afterwards.
- Backpressure: out_ready = 0 when the first window appears → in_ready = 0 and shift_en = 0, and win_valid and coordinates hold (1,1). Raise out_ready 3 cycles later → the next pixel is accepted in that cycle and the window advances to (1,2).
- Upstream bubbles: in_valid toggled 1/0 → counters advance only on accepted cycles. Window coordinates match the full-rate case, and the total accept count is 12.
- Row wrap / boundary: after pixel (1,3), the accept at (2,0) and (2,1) produces no window and no stale win_valid. Check win_valid = 0 at pixel 8+1 and 9+1.
- Control robustness: start pulsed during RUN → no counter reset. rst asserted mid-frame → next cycle state IDLE with all outputs at reset values. A new start then completes a correct frame.
- Parameter sweep: IMG_W=8, IMG_H=6, K=5 at full rate → (6−4)·(8−4) = 8 windows, with centres row 2..3 and col 2..5.
